// File: rtl/cmd_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_scheduler
// Pops 80-bit commands from the command FIFO. Each command is held until the
// global_clock time stamp falls due, then it is presented to the pin units on
// a valid/ready bus. Only one command is in flight at a time.
//
// Command word layout:
//   [79:48] start_time  [47:32] unit_addr  [31:16] unit_cmd  [15:0] unit_data
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   fifo_dout         FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO pop strobe (never asserted while fifo_empty)
//   global_clock      free-running 32-bit timebase
//   flush             abort current command and drain the FIFO
//   unit_addr/cmd/data  captured command fields, stable while unit_valid
//   unit_valid        command presented to the units
//   unit_ready        unit accepts the presented command
//   busy              high in any state other than IDLE
//   late_count        saturating count of issues later than LATE_THRESHOLD
//   timeout_count     saturating count of commands dropped on ack timeout
// -----------------------------------------------------------------------------
module cmd_scheduler #(
    parameter int unsigned ACK_TIMEOUT    = 1024,
    parameter int unsigned LATE_THRESHOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] global_clock,
    input  logic        flush,
    output logic [15:0] unit_addr,
    output logic [15:0] unit_cmd,
    output logic [15:0] unit_data,
    output logic        unit_valid,
    input  logic        unit_ready,
    output logic        busy,
    output logic [15:0] late_count,
    output logic [15:0] timeout_count
);

    localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_DRAIN_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   start_q;
    logic [15:0]   addr_q, cmd_q, data_q;
    logic [15:0]   late_q, tmo_q;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          rd_en;
    logic          cap_en;
    logic          late_inc;
    logic          tmo_inc;
    logic [31:0]   diff;

    // Modular difference: bit 31 clear means the time stamp is due, which
    // also covers a start_time that lies just past a global_clock wrap.
    assign diff = global_clock - start_q;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        rd_en    = 1'b0;
        cap_en   = 1'b0;
        late_inc = 1'b0;
        tmo_inc  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    if (!fifo_empty) state_d = S_DRAIN;
                end else if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    cap_en  = 1'b1;
                    state_d = (fifo_dout[31:16] == 16'h0000) ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (!diff[31]) begin
                    state_d  = S_ISSUE;
                    tcnt_d   = '0;
                    late_inc = (diff > 32'(LATE_THRESHOLD));
                end
            end
            S_ISSUE: begin
                // A handshake in the same cycle as flush still completes;
                // flush only redirects the next state.
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (unit_ready) begin
                    state_d = S_IDLE;
                end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_inc = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = S_DRAIN_GAP;
                end
            end
            S_DRAIN_GAP: begin
                // Popped data arrives here and is discarded.
                state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            late_q  <= '0;
            tmo_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            if (cap_en) begin
                start_q <= fifo_dout[79:48];
                addr_q  <= fifo_dout[47:32];
                cmd_q   <= fifo_dout[31:16];
                data_q  <= fifo_dout[15:0];
            end
            if (late_inc && (late_q != '1)) late_q <= late_q + 16'd1;
            if (tmo_inc && (tmo_q != '1))   tmo_q  <= tmo_q + 16'd1;
        end
    end

    // Strobes are gated by rst so nothing is popped or presented while the
    // synchronous reset is being applied.
    assign fifo_rd_en    = rd_en && !rst;
    assign unit_valid    = (state_q == S_ISSUE) && !rst;
    assign busy          = (state_q != S_IDLE) && !rst;
    assign unit_addr     = addr_q;
    assign unit_cmd      = cmd_q;
    assign unit_data     = data_q;
    assign late_count    = late_q;
    assign timeout_count = tmo_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
module tb_cmd_scheduler;

    localparam int unsigned ACK = 1024;

    logic        clk;
    logic        rst;
    logic [79:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] global_clock;
    logic        flush;
    logic [15:0] unit_addr, unit_cmd, unit_data;
    logic        unit_valid;
    logic        unit_ready;
    logic        busy;
    logic [15:0] late_count, timeout_count;

    cmd_scheduler #(.ACK_TIMEOUT(ACK), .LATE_THRESHOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .global_clock (global_clock),
        .flush        (flush),
        .unit_addr    (unit_addr),
        .unit_cmd     (unit_cmd),
        .unit_data    (unit_data),
        .unit_valid   (unit_valid),
        .unit_ready   (unit_ready),
        .busy         (busy),
        .late_count   (late_count),
        .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timebase: free-running cycle count plus an offset the stimulus can move.
    logic [31:0] cyc;
    logic [31:0] gc_offset;
    assign global_clock = cyc + gc_offset;

    // FIFO model: single process owns the queue; data appears the cycle after a pop.
    logic [79:0] fifo_q[$];
    logic        push_req;
    logic [79:0] push_data;
    logic [31:0] pop_cyc;

    initial begin
        cyc        <= '0;
        fifo_dout  <= '0;
        fifo_empty <= 1'b1;
        pop_cyc    <= '0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 32'd1;
            if (fifo_rd_en && fifo_q.size() > 0) begin
                fifo_dout <= fifo_q.pop_front();
                pop_cyc   <= cyc;
            end
            if (push_req) fifo_q.push_back(push_data);
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard entries: expected issues and expected status snapshots.
    typedef struct {
        logic [15:0] addr;
        logic [15:0] cmd;
        logic [15:0] data;
        bit          chk_gc;
        logic [31:0] exp_gc;
        bit          chk_lat;
        bit          exp_tmo;
    } exp_t;

    typedef struct {
        bit          expired;
        logic [15:0] late;
        logic [15:0] tmo;
        bit          zero_out;
    } stat_t;

    exp_t  sb[$];
    stat_t stat_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the only process that compares and steps the counters.
    initial begin
        exp_t  cur;
        stat_t s;
        bit    in_xfer;
        bit    have_cur;
        int    dur;
        in_xfer  = 1'b0;
        have_cur = 1'b0;
        dur      = 0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
            if (unit_valid && !in_xfer) begin
                in_xfer = 1'b1;
                dur     = 1;
                if (sb.size() == 0) begin
                    have_cur = 1'b0;
                    chk("unexpected_issue", 32'(unit_cmd), 32'hFFFF_FFFF);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    chk("issue_addr", 32'(unit_addr), 32'(cur.addr));
                    chk("issue_cmd",  32'(unit_cmd),  32'(cur.cmd));
                    chk("issue_data", 32'(unit_data), 32'(cur.data));
                    if (cur.chk_gc)  chk("issue_time", global_clock, cur.exp_gc);
                    if (cur.chk_lat) chk("pop_to_issue", cyc - pop_cyc, 32'd3);
                end
            end else if (unit_valid && in_xfer) begin
                dur++;
                if (have_cur) chk("valid_stable", {unit_addr, unit_data}, {cur.addr, cur.data});
            end else if (!unit_valid && in_xfer) begin
                in_xfer = 1'b0;
                if (have_cur && cur.exp_tmo) chk("timeout_len", 32'(dur), 32'(ACK));
            end
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                if (s.expired) begin
                    chk("wait_bound", 32'd1, 32'd0);
                end else begin
                    chk("late_count",    32'(late_count),    32'(s.late));
                    chk("timeout_count", 32'(timeout_count), 32'(s.tmo));
                    chk("busy",          32'(busy),          32'd0);
                    chk("fifo_empty",    32'(fifo_empty),    32'd1);
                    chk("sb_drained",    32'(sb.size()),     32'd0);
                    if (s.zero_out) begin
                        chk("rst_valid", 32'(unit_valid), 32'd0);
                        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
                        chk("rst_fields", {unit_addr, unit_cmd}, 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gc(input logic [31:0] v);
        gc_offset = v - cyc;
    endtask

    task automatic push_word(input logic [31:0] st, input logic [15:0] a,
                             input logic [15:0] c, input logic [15:0] d);
        push_data = {st, a, c, d};
        push_req  = 1'b1;
        step();
        push_req  = 1'b0;
    endtask

    task automatic expect_issue(input logic [15:0] a, input logic [15:0] c, input logic [15:0] d,
                                input bit cg, input logic [31:0] g, input bit cl, input bit tmo);
        exp_t e;
        e.addr = a; e.cmd = c; e.data = d;
        e.chk_gc = cg; e.exp_gc = g; e.chk_lat = cl; e.exp_tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic check_stat(input logic [15:0] late, input logic [15:0] tmo, input bit z);
        stat_t s;
        s.expired = 1'b0; s.late = late; s.tmo = tmo; s.zero_out = z;
        stat_q.push_back(s);
    endtask

    task automatic report_expired();
        stat_t s;
        s.expired = 1'b1; s.late = '0; s.tmo = '0; s.zero_out = 1'b0;
        stat_q.push_back(s);
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        repeat (2) step();
        for (int i = 0; i < limit; i++) begin
            if (!busy && fifo_empty && !unit_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) report_expired();
    endtask

    logic [31:0] st, st2;

    initial begin
        bit seen;
        rst        = 1'b1;
        flush      = 1'b0;
        unit_ready = 1'b1;
        push_req   = 1'b0;
        push_data  = '0;
        gc_offset  = '0;
        repeat (3) step();
        check_stat(16'd0, 16'd0, 1'b1);
        step();
        rst = 1'b0;
        step();

        // Future command: valid first seen the cycle after global_clock == start.
        set_gc(32'd100);
        push_word(32'd200, 16'd3, 16'd1, 16'h00AB);
        expect_issue(16'd3, 16'd1, 16'h00AB, 1'b1, 32'd201, 1'b0, 1'b0);
        wait_idle(500);
        check_stat(16'd0, 16'd0, 1'b0);

        // Already overdue: IDLE, LATCH, WAIT then ISSUE; counts as late.
        set_gc(32'd500);
        push_word(32'd100, 16'd5, 16'd2, 16'h1234);
        expect_issue(16'd5, 16'd2, 16'h1234, 1'b0, 32'd0, 1'b1, 1'b0);
        wait_idle(100);
        check_stat(16'd1, 16'd0, 1'b0);

        // Start time across the 32-bit wrap: issued at gc==5, seen at gc==6.
        set_gc(32'hFFFF_FFF0);
        push_word(32'd5, 16'd7, 16'd3, 16'h55AA);
        expect_issue(16'd7, 16'd3, 16'h55AA, 1'b1, 32'd6, 1'b0, 1'b0);
        wait_idle(200);
        check_stat(16'd1, 16'd0, 1'b0);

        // Ack timeout, then the next FIFO word is popped and issued.
        unit_ready = 1'b0;
        st = global_clock + 32'd20;
        push_word(st, 16'h0011, 16'd4, 16'hC0DE);
        expect_issue(16'h0011, 16'd4, 16'hC0DE, 1'b1, st + 32'd1, 1'b0, 1'b1);
        st2 = global_clock + 32'd1100;
        push_word(st2, 16'h0012, 16'd5, 16'hBEEF);
        expect_issue(16'h0012, 16'd5, 16'hBEEF, 1'b1, st2 + 32'd1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (timeout_count == 16'd1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) report_expired();
        unit_ready = 1'b1;
        wait_idle(500);
        check_stat(16'd1, 16'd1, 1'b0);

        // Flush while the first of three commands waits: nothing issued, FIFO drained.
        st = global_clock + 32'd60;
        push_word(st,          16'h0021, 16'd6, 16'h0001);
        push_word(st + 32'd1,  16'h0022, 16'd7, 16'h0002);
        push_word(st + 32'd2,  16'h0023, 16'd8, 16'h0003);
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(100);
        check_stat(16'd1, 16'd1, 1'b0);

        // NOP word: popped, never issued, and not counted late despite start=0.
        push_word(32'd0, 16'd9, 16'd0, 16'h0001);
        wait_idle(50);
        check_stat(16'd1, 16'd1, 1'b0);

        // Reset while a command is presented: valid drops, counters clear.
        unit_ready = 1'b0;
        st = global_clock + 32'd5;
        push_word(st, 16'h0031, 16'd9, 16'h7777);
        expect_issue(16'h0031, 16'd9, 16'h7777, 1'b1, st + 32'd1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (unit_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) report_expired();
        repeat (3) step();
        rst = 1'b1;
        step();
        check_stat(16'd0, 16'd0, 1'b1);
        step();
        rst = 1'b0;
        unit_ready = 1'b1;
        repeat (3) step();
        check_stat(16'd0, 16'd0, 1'b0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
